// File: rtl/wall_clock_param.sv
// Board wall clock: BCD HH:MM:SS from a tick prescaler, debounced auto-repeat set buttons,
// 12/24 h display on a 4- or 6-digit multiplexed seven-segment with PWM brightness.
module wall_clock_param #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SCAN_CYC      = 100_000,
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter int unsigned REPEAT_CYC    = 25_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_BTN,
  input  logic       INC_MIN,
  input  logic       INC_HOUR,
  input  logic       MODE_12H,
  input  logic [7:0] pwm_in,
  output logic [5:0] LED,
  output logic [7:0] SevenSegment,
  output logic [7:0] SegmentDrivers
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SW = $clog2(SCAN_CYC + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RW = $clog2(REPEAT_CYC + 1);

  localparam logic [PW-1:0] PrescMax  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PrescHalf = PW'(TICKS_PER_SEC / 2);
  localparam logic [SW-1:0] ScanMax   = SW'(SCAN_CYC - 1);
  localparam logic [DW-1:0] DebMax    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] RepMax    = RW'(REPEAT_CYC - 1);
  localparam logic [2:0]    IdxMax    = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]    DigitMask = 8'((1 << NUM_DIGITS) - 1);

  // ---------------------------------------------------------------------------
  // Set buttons: synchroniser, debouncer, auto-repeat pulse generator
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;

  assign btn_raw = {INC_HOUR, INC_MIN};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0]    sync_q;
    logic          deb_q;
    logic [DW-1:0] deb_cnt_q;
    logic [RW-1:0] rep_cnt_q;
    logic          pulse_q;

    always_ff @(posedge CLK100MHZ or negedge RESET_BTN) begin
      if (!RESET_BTN) begin
        sync_q    <= 2'b00;
        deb_q     <= 1'b0;
        deb_cnt_q <= '0;
        rep_cnt_q <= '0;
        pulse_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], btn_raw[b]};
        pulse_q <= 1'b0;

        if (sync_q[1] == deb_q) begin
          deb_cnt_q <= '0;
        end else if (deb_cnt_q == DebMax) begin
          deb_cnt_q <= '0;
          deb_q     <= sync_q[1];
          pulse_q   <= sync_q[1];
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end

        // Repeat only while both the accepted and the live level are high.
        if (deb_q && sync_q[1]) begin
          if (rep_cnt_q == RepMax) begin
            rep_cnt_q <= '0;
            pulse_q   <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end else begin
          rep_cnt_q <= '0;
        end
      end
    end

    assign btn_pulse[b] = pulse_q;
  end

  logic inc_min, inc_hour;
  assign inc_min  = btn_pulse[0];
  assign inc_hour = btn_pulse[1];

  logic [1:0] mode_sync_q;
  logic       mode12;
  assign mode12 = mode_sync_q[1];

  // ---------------------------------------------------------------------------
  // Prescaler and BCD timekeeping
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick;
  logic [1:0]    hh_t_q, hh_t_d;
  logic [3:0]    hh_o_q, hh_o_d;
  logic [2:0]    mm_t_q, mm_t_d;
  logic [3:0]    mm_o_q, mm_o_d;
  logic [2:0]    ss_t_q, ss_t_d;
  logic [3:0]    ss_o_q, ss_o_d;
  logic          min_carry;

  assign sec_tick = (presc_q == PrescMax);

  always_comb begin
    presc_d   = sec_tick ? '0 : presc_q + 1'b1;
    hh_t_d    = hh_t_q;
    hh_o_d    = hh_o_q;
    mm_t_d    = mm_t_q;
    mm_o_d    = mm_o_q;
    ss_t_d    = ss_t_q;
    ss_o_d    = ss_o_q;
    min_carry = 1'b0;

    if (inc_min) begin
      // Manual minute set swallows any coincident tick and restarts the second.
      presc_d = '0;
      ss_t_d  = 3'd0;
      ss_o_d  = 4'd0;
      if (mm_o_q == 4'd9) begin
        mm_o_d = 4'd0;
        mm_t_d = (mm_t_q == 3'd5) ? 3'd0 : mm_t_q + 3'd1;
      end else begin
        mm_o_d = mm_o_q + 4'd1;
      end
    end else if (sec_tick) begin
      if (ss_o_q != 4'd9) begin
        ss_o_d = ss_o_q + 4'd1;
      end else begin
        ss_o_d = 4'd0;
        if (ss_t_q != 3'd5) begin
          ss_t_d = ss_t_q + 3'd1;
        end else begin
          ss_t_d = 3'd0;
          if (mm_o_q != 4'd9) begin
            mm_o_d = mm_o_q + 4'd1;
          end else begin
            mm_o_d = 4'd0;
            if (mm_t_q != 3'd5) begin
              mm_t_d = mm_t_q + 3'd1;
            end else begin
              mm_t_d    = 3'd0;
              min_carry = 1'b1;
            end
          end
        end
      end
    end

    if (inc_hour || min_carry) begin
      if (hh_t_q == 2'd2 && hh_o_q == 4'd3) begin
        hh_t_d = 2'd0;
        hh_o_d = 4'd0;
      end else if (hh_o_q == 4'd9) begin
        hh_o_d = 4'd0;
        hh_t_d = hh_t_q + 2'd1;
      end else begin
        hh_o_d = hh_o_q + 4'd1;
      end
    end
  end

  logic [5:0] led_q;

  always_ff @(posedge CLK100MHZ or negedge RESET_BTN) begin
    if (!RESET_BTN) begin
      presc_q     <= '0;
      hh_t_q      <= 2'd0;
      hh_o_q      <= 4'd0;
      mm_t_q      <= 3'd0;
      mm_o_q      <= 4'd0;
      ss_t_q      <= 3'd0;
      ss_o_q      <= 4'd0;
      led_q       <= 6'd0;
      mode_sync_q <= 2'b00;
    end else begin
      presc_q     <= presc_d;
      hh_t_q      <= hh_t_d;
      hh_o_q      <= hh_o_d;
      mm_t_q      <= mm_t_d;
      mm_o_q      <= mm_o_d;
      ss_t_q      <= ss_t_d;
      ss_o_q      <= ss_o_d;
      led_q       <= 6'(ss_t_q) * 6'd10 + 6'(ss_o_q);
      mode_sync_q <= {mode_sync_q[0], MODE_12H};
    end
  end

  assign LED = led_q;

  // ---------------------------------------------------------------------------
  // Hour presentation (12/24 h)
  // ---------------------------------------------------------------------------
  logic [4:0] hh_bin, hh12;
  logic       pm, hh_blank;
  logic [3:0] h_tens, h_ones;

  always_comb begin
    hh_bin = {hh_t_q, 3'b000} + {2'b00, hh_t_q, 1'b0} + {1'b0, hh_o_q};
    pm     = (hh_bin >= 5'd12);
    if (hh_bin == 5'd0) begin
      hh12 = 5'd12;
    end else if (hh_bin > 5'd12) begin
      hh12 = hh_bin - 5'd12;
    end else begin
      hh12 = hh_bin;
    end

    if (mode12) begin
      hh_blank = (hh12 < 5'd10);
      h_tens   = hh_blank ? 4'd0 : 4'd1;
      h_ones   = hh_blank ? hh12[3:0] : 4'(hh12 - 5'd10);
    end else begin
      hh_blank = 1'b0;
      h_tens   = {2'b00, hh_t_q};
      h_ones   = hh_o_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit multiplexing, PWM and registered drivers
  // ---------------------------------------------------------------------------
  logic [SW-1:0] scan_cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    pwm_cnt_q;
  logic [7:0]    seg_q, drv_q;
  logic [3:0]    dig_val;
  logic          dig_blank, dig_dp, sep_on, pm_dp, enable;
  logic [7:0]    seg_next;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  assign sep_on = (presc_q < PrescHalf);
  assign pm_dp  = mode12 & pm;
  assign enable = (pwm_cnt_q < pwm_in);

  always_comb begin
    dig_val   = 4'd0;
    dig_blank = 1'b0;
    dig_dp    = 1'b0;
    if (NUM_DIGITS == 6) begin
      case (idx_q)
        3'd0: begin dig_val = ss_o_q; dig_dp = pm_dp; end
        3'd1: dig_val = {1'b0, ss_t_q};
        3'd2: begin dig_val = mm_o_q; dig_dp = sep_on; end
        3'd3: dig_val = {1'b0, mm_t_q};
        3'd4: begin dig_val = h_ones; dig_dp = sep_on; end
        3'd5: begin dig_val = h_tens; dig_blank = hh_blank; end
        default: dig_blank = 1'b1;
      endcase
    end else begin
      case (idx_q)
        3'd0: begin dig_val = mm_o_q; dig_dp = pm_dp; end
        3'd1: dig_val = {1'b0, mm_t_q};
        3'd2: begin dig_val = h_ones; dig_dp = sep_on; end
        3'd3: begin dig_val = h_tens; dig_blank = hh_blank; end
        default: dig_blank = 1'b1;
      endcase
    end
    seg_next = dig_blank ? 8'hFF : (glyph(dig_val) & ~{dig_dp, 7'b000_0000});
  end

  always_ff @(posedge CLK100MHZ or negedge RESET_BTN) begin
    if (!RESET_BTN) begin
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
      pwm_cnt_q  <= 8'd0;
      seg_q      <= 8'hFF;
      drv_q      <= 8'hFF;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (scan_cnt_q == ScanMax) begin
        scan_cnt_q <= '0;
        idx_q      <= (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      if (enable) begin
        seg_q <= seg_next;
        drv_q <= ~((8'h01 << idx_q) & DigitMask);
      end else begin
        seg_q <= 8'hFF;
        drv_q <= 8'hFF;
      end
    end
  end

  assign SevenSegment   = seg_q;
  assign SegmentDrivers = drv_q;

endmodule

// File: tb/tb_wall_clock_param.sv
// Directed bench for wall_clock_param: 6-digit build with a 10-cycle second.
module tb_wall_clock_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inc_min, inc_hour, mode_12h;
  logic [7:0] pwm;
  logic [5:0] led;
  logic [7:0] seg, drv;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wall_clock_param #(
    .TICKS_PER_SEC(10),
    .NUM_DIGITS   (6),
    .SCAN_CYC     (2),
    .DEBOUNCE_CYC (4),
    .REPEAT_CYC   (20)
  ) dut (
    .CLK100MHZ     (clk),
    .RESET_BTN     (rst_n),
    .INC_MIN       (inc_min),
    .INC_HOUR      (inc_hour),
    .MODE_12H      (mode_12h),
    .pwm_in        (pwm),
    .LED           (led),
    .SevenSegment  (seg),
    .SegmentDrivers(drv)
  );

  typedef struct {
    int         hp;    // hour presses before the check
    logic       mode;  // MODE_12H
    int         dig;
    logic [7:0] mask;  // bits ignored
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_digit(input int k, output logic [7:0] s);
    logic [7:0] want;
    want = ~(8'h01 << k);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (drv == want) begin
        s = seg;
        return;
      end
    end
    s = 8'h00;
    checks++;
    failures++;
    $display("FAIL digit_timeout: digit %0d never selected, drivers=%0h", k, drv);
  endtask

  task automatic check_digit(input string name, input int k, input logic [7:0] mask,
                             input logic [7:0] exp);
    logic [7:0] s;
    read_digit(k, s);
    check(name, s | mask, exp | mask);
  endtask

  task automatic press(input logic m, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      inc_min  = m;
      inc_hour = h;
      repeat (8) @(negedge clk);
      inc_min  = 1'b0;
      inc_hour = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  // Press held 10 cycles: the accepted edge has landed but the next tick has not.
  task automatic press_led(input logic m, input logic h, input string name);
    inc_min  = m;
    inc_hour = h;
    repeat (10) @(negedge clk);
    check(name, led, 0);
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_led(input logic [5:0] val, input int bound, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (led == val) found = 1'b1;
    end
    check(name, found, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] prev_led;
  int         changes, bad, active, run, prev_dig, dig, exp_s;
  bit         first_run, saw_lit, saw_dark;
  logic [7:0] v;

  initial begin
    vecs[0]  = '{3,  1'b1, 5, 8'h00, 8'hFF};  // 13:05, 12 h -> blank tens
    vecs[1]  = '{0,  1'b1, 4, 8'h80, 8'hF9};
    vecs[2]  = '{0,  1'b1, 0, 8'h7F, 8'h00};  // PM dot lit
    vecs[3]  = '{0,  1'b1, 3, 8'h80, 8'hC0};
    vecs[4]  = '{0,  1'b1, 2, 8'h80, 8'h92};
    vecs[5]  = '{0,  1'b0, 5, 8'h00, 8'hF9};  // 24 h: 13
    vecs[6]  = '{0,  1'b0, 4, 8'h80, 8'hB0};
    vecs[7]  = '{0,  1'b0, 0, 8'h7F, 8'h80};
    vecs[8]  = '{11, 1'b1, 5, 8'h00, 8'hF9};  // 00 -> 12
    vecs[9]  = '{0,  1'b1, 4, 8'h80, 8'hA4};
    vecs[10] = '{0,  1'b1, 0, 8'h7F, 8'hFF};  // AM
    vecs[11] = '{0,  1'b0, 5, 8'h00, 8'hC0};
    vecs[12] = '{0,  1'b0, 4, 8'h80, 8'hC0};
    vecs[13] = '{1,  1'b1, 5, 8'h00, 8'hFF};  // 01 -> blank, 1
    vecs[14] = '{0,  1'b1, 4, 8'h80, 8'hF9};
    vecs[15] = '{11, 1'b1, 5, 8'h00, 8'hF9};  // 12 noon
    vecs[16] = '{0,  1'b1, 4, 8'h80, 8'hA4};
    vecs[17] = '{0,  1'b1, 0, 8'h7F, 8'h00};

    rst_n    = 1'b0;
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    mode_12h = 1'b0;
    pwm      = 8'd255;
    repeat (3) @(negedge clk);
    check("reset_seg", seg, 8'hFF);
    check("reset_drv", drv, 8'hFF);
    check("reset_led", led, 0);
    rst_n = 1'b1;

    // Free run: one full minute of seconds.
    prev_led = 6'd0;
    changes  = 0;
    for (int c = 0; c < 700 && changes < 60; c++) begin
      @(negedge clk);
      if (led != prev_led) begin
        exp_s = (int'(prev_led) + 1) % 60;
        check("led_step", led, exp_s);
        prev_led = led;
        changes++;
      end
    end
    check("led_minute_count", changes, 60);
    check_digit("run_sec_tens", 1, 8'h00, 8'hC0);
    check_digit("run_min_ones", 2, 8'h80, 8'hF9);
    check_digit("run_min_tens", 3, 8'h00, 8'hC0);
    check_digit("run_hour_ones", 4, 8'h80, 8'hC0);
    check_digit("run_hour_tens", 5, 8'h00, 8'hC0);

    // Scan order and dwell, pwm fully on.
    bad       = 0;
    prev_dig  = -1;
    run       = 0;
    first_run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (drv == 8'hFF) begin
        prev_dig  = -1;
        first_run = 1'b1;
      end else begin
        dig = -1;
        for (int i = 0; i < 8; i++) if (drv[i] == 1'b0) dig = i;
        if (prev_dig < 0) begin
          prev_dig = dig;
          run      = 1;
        end else if (dig == prev_dig) begin
          run++;
        end else begin
          if (!first_run && run != 2) bad++;
          if (dig != (prev_dig + 1) % 6) bad++;
          first_run = 1'b0;
          prev_dig  = dig;
          run       = 1;
        end
      end
    end
    check("scan_order", bad, 0);

    // Glitch shorter than the debounce window is ignored.
    inc_min = 1'b1;
    repeat (3) @(negedge clk);
    inc_min = 1'b0;
    repeat (12) @(negedge clk);
    check_digit("glitch_min_ones", 2, 8'h80, 8'hF9);

    // Held 30 cycles: initial pulse plus one repeat.
    inc_min = 1'b1;
    repeat (30) @(negedge clk);
    check("hold_ss_clear", led, 0);
    inc_min = 1'b0;
    repeat (10) @(negedge clk);
    check_digit("hold_min_ones", 2, 8'h80, 8'hB0);
    check_digit("hold_min_tens", 3, 8'h00, 8'hC0);

    // Preload 23:59 and roll over midnight.
    press(1'b0, 1'b1, 23);
    press(1'b1, 1'b0, 56);
    check_digit("pre_hour_tens", 5, 8'h00, 8'hA4);
    check_digit("pre_hour_ones", 4, 8'h80, 8'hB0);
    check_digit("pre_min_tens", 3, 8'h00, 8'h92);
    check_digit("pre_min_ones", 2, 8'h80, 8'h90);
    wait_led(6'd59, 700, "reach_235959");
    wait_led(6'd0, 20, "midnight_led");
    check_digit("mid_hour_tens", 5, 8'h00, 8'hC0);
    check_digit("mid_hour_ones", 4, 8'h80, 8'hC0);
    check_digit("mid_min_tens", 3, 8'h00, 8'hC0);
    check_digit("mid_min_ones", 2, 8'h80, 8'hC0);

    // Manual minute wrap does not carry into hours.
    press(1'b0, 1'b1, 9);
    press(1'b1, 1'b0, 59);
    check_digit("h9_min_tens", 3, 8'h00, 8'h92);
    check_digit("h9_min_ones", 2, 8'h80, 8'h90);
    press_led(1'b1, 1'b0, "wrap_ss_clear");
    check_digit("wrap_hour_tens", 5, 8'h00, 8'hC0);
    check_digit("wrap_hour_ones", 4, 8'h80, 8'h90);
    check_digit("wrap_min_tens", 3, 8'h00, 8'hC0);
    check_digit("wrap_min_ones", 2, 8'h80, 8'hC0);

    // Both buttons together at 09:59:30.
    press(1'b1, 1'b0, 59);
    wait_led(6'd30, 400, "reach_095930");
    press_led(1'b1, 1'b1, "both_ss_clear");
    check_digit("both_hour_tens", 5, 8'h00, 8'hF9);
    check_digit("both_hour_ones", 4, 8'h80, 8'hC0);
    check_digit("both_min_tens", 3, 8'h00, 8'hC0);
    check_digit("both_min_ones", 2, 8'h80, 8'hC0);

    // 12/24 h display table, starting from 10:05.
    press(1'b1, 1'b0, 5);
    for (int i = 0; i < 18; i++) begin
      press(1'b0, 1'b1, vecs[i].hp);
      mode_12h = vecs[i].mode;
      repeat (4) @(negedge clk);
      check_digit($sformatf("mode_vec%0d", i), vecs[i].dig, vecs[i].mask, vecs[i].exp);
    end

    // Separator dot on hours-ones blinks.
    saw_lit  = 1'b0;
    saw_dark = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (drv == 8'hEF) begin
        if (seg[7]) saw_dark = 1'b1;
        else        saw_lit  = 1'b1;
      end
    end
    check("sep_blink", {saw_lit, saw_dark}, 2'b11);

    // Brightness.
    pwm = 8'd0;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (drv != 8'hFF || seg != 8'hFF) bad++;
    end
    check("pwm_zero_dark", bad, 0);

    pwm = 8'd128;
    repeat (3) @(negedge clk);
    bad    = 0;
    active = 0;
    for (int c = 0; c < 512; c++) begin
      @(negedge clk);
      v = ~drv;
      if (v != 8'h00) begin
        active++;
        if (v[7:6] != 2'b00 || $countones(v) != 1) bad++;
      end else if (seg != 8'hFF) begin
        bad++;
      end
    end
    check("pwm_half_active", active, 256);
    check("pwm_onehot", bad, 0);

    // Asynchronous reset between clock edges.
    pwm = 8'd255;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg, 8'hFF);
    check("async_rst_drv", drv, 8'hFF);
    check("async_rst_led", led, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
